ctrl_fsm: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle opcode decoder. It registers the 16-entry ISA decode (NOP..HALT) onto the datapath select, ALU, write and jump controls. It also sequences load wait states, branch/jump flush bubbles and a sticky HALT, and drives a stall to the fetch stage. It sits between instruction fetch (opcode source) and the register-file/ALU/PC datapath.

---
 rtl/ctrl_fsm.sv | 193 +++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: registered multi-cycle control decoder.
// Decodes the 16-entry ISA onto datapath selects, ALU op, write enable and
// jump controls, and sequences load wait states, branch/jump flush bubbles
// and a sticky HALT. stall tells fetch to hold PC and opcd.
module ctrl_fsm #(
   parameter int LD_LAT    = 2,  // memory read wait cycles for LD (1..15)
   parameter int FLUSH_CYC = 1,  // bubbles after a taken branch or JUMP (0..7)
   parameter int OPW       = 4   // opcode width, low 4 bits decoded
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcd,
   input  logic           instr_valid,
   input  logic           br_taken,
   output logic           sel1,
   output logic           sel2,
   output logic           sel,
   output logic           w,
   output logic [1:0]     ALU,
   output logic [1:0]     jump,
   output logic           mem_rd,
   output logic           mem_wr,
   output logic           stall,
   output logic           halted
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LDWAIT = 2'd1,
      FLUSH  = 2'd2,
      HALT   = 2'd3
   } state_t;

   // The redirect cycle itself is the first bubble, so the FLUSH state only
   // has to cover the remaining FLUSH_CYC-1 bubbles.
   localparam logic [3:0] LD_INIT     = 4'(LD_LAT - 1);
   localparam bit         FLUSH_EN    = (FLUSH_CYC > 0);
   localparam bit         FLUSH_MULTI = (FLUSH_CYC > 1);
   localparam logic [2:0] FL_INIT     = FLUSH_MULTI ? 3'(FLUSH_CYC - 2) : 3'd0;

   state_t     state_q, state_d;
   logic [3:0] ld_cnt_q, ld_cnt_d;
   logic [2:0] fl_cnt_q, fl_cnt_d;

   logic       sel1_q, sel1_d;
   logic       sel2_q, sel2_d;
   logic       sel_q, sel_d;
   logic       w_q, w_d;
   logic [1:0] alu_q, alu_d;
   logic [1:0] jump_q, jump_d;
   logic       mem_rd_q, mem_rd_d;
   logic       mem_wr_q, mem_wr_d;
   logic       stall_q, stall_d;
   logic       halted_q, halted_d;

   logic [3:0] opc;
   logic       upper_nz;
   logic       redirect;

   assign opc = opcd[3:0];

   // Any set bit above the decoded nibble turns the instruction into a NOP.
   if (OPW > 4) begin : g_upper
      assign upper_nz = |opcd[OPW-1:4];
   end else begin : g_no_upper
      assign upper_nz = 1'b0;
   end

   // jump_q is only nonzero in the cycle a branch/jump is being presented, so
   // br_taken is only consulted in that cycle.
   assign redirect = (jump_q == 2'b11) ||
                     (((jump_q == 2'b01) || (jump_q == 2'b10)) && br_taken);

   // Next-state and next-output logic; every output defaults to NOP.
   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      fl_cnt_d = fl_cnt_q;
      sel1_d   = 1'b0;
      sel2_d   = 1'b0;
      sel_d    = 1'b0;
      w_d      = 1'b0;
      alu_d    = 2'b00;
      jump_d   = 2'b00;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      stall_d  = 1'b0;
      halted_d = 1'b0;
      case (state_q)
         HALT: begin
            halted_d = 1'b1;
            stall_d  = 1'b1;
         end
         LDWAIT: begin
            if (ld_cnt_q != 4'd0) begin
               mem_rd_d = 1'b1;
               stall_d  = 1'b1;
               ld_cnt_d = ld_cnt_q - 4'd1;
            end else begin
               w_d     = 1'b1;
               state_d = RUN;
            end
         end
         FLUSH: begin
            if (fl_cnt_q == 3'd0) begin
               state_d = RUN;
            end else begin
               fl_cnt_d = fl_cnt_q - 3'd1;
            end
         end
         default: begin
            if (redirect && FLUSH_EN) begin
               if (FLUSH_MULTI) begin
                  state_d  = FLUSH;
                  fl_cnt_d = FL_INIT;
               end
            end else if (instr_valid && !upper_nz) begin
               case (opc)
                  4'h1: w_d = 1'b1;
                  4'h2: begin w_d = 1'b1; alu_d = 2'b01; end
                  4'h3: begin w_d = 1'b1; alu_d = 2'b10; end
                  4'h4: begin w_d = 1'b1; alu_d = 2'b11; end
                  4'h5: begin sel2_d = 1'b1; w_d = 1'b1; end
                  4'h6: begin sel1_d = 1'b1; sel2_d = 1'b1; w_d = 1'b1; end
                  4'h7: begin sel2_d = 1'b1; w_d = 1'b1; alu_d = 2'b01; end
                  4'h8, 4'h9: begin sel_d = 1'b1; w_d = 1'b1; end
                  4'hA: begin
                     mem_rd_d = 1'b1;
                     stall_d  = 1'b1;
                     ld_cnt_d = LD_INIT;
                     state_d  = LDWAIT;
                  end
                  4'hB: mem_wr_d = 1'b1;
                  4'hC: jump_d = 2'b01;
                  4'hD: jump_d = 2'b10;
                  4'hE: jump_d = 2'b11;
                  4'hF: begin
                     halted_d = 1'b1;
                     stall_d  = 1'b1;
                     state_d  = HALT;
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   // State, counters and registered outputs; reset wins from any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         ld_cnt_q <= 4'd0;
         fl_cnt_q <= 3'd0;
         sel1_q   <= 1'b0;
         sel2_q   <= 1'b0;
         sel_q    <= 1'b0;
         w_q      <= 1'b0;
         alu_q    <= 2'b00;
         jump_q   <= 2'b00;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         stall_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ld_cnt_q <= ld_cnt_d;
         fl_cnt_q <= fl_cnt_d;
         sel1_q   <= sel1_d;
         sel2_q   <= sel2_d;
         sel_q    <= sel_d;
         w_q      <= w_d;
         alu_q    <= alu_d;
         jump_q   <= jump_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
         stall_q  <= stall_d;
         halted_q <= halted_d;
      end
   end

   assign sel1   = sel1_q;
   assign sel2   = sel2_q;
   assign sel    = sel_q;
   assign w      = w_q;
   assign ALU    = alu_q;
   assign jump   = jump_q;
   assign mem_rd = mem_rd_q;
   assign mem_wr = mem_wr_q;
   assign stall  = stall_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: scoreboard bench for ctrl_fsm. Two instances share the inputs:
// dut_a (LD_LAT=2, FLUSH_CYC=1) and dut_b (LD_LAT=1, FLUSH_CYC=0).
// Output vector layout: {sel1,sel2,sel,w,ALU[1:0],jump[1:0],mem_rd,mem_wr,stall,halted}
module tb_ctrl_fsm;

   localparam logic [11:0] E_NOP   = 12'h000;
   localparam logic [11:0] E_ADD   = 12'h100;
   localparam logic [11:0] E_SUB   = 12'h140;
   localparam logic [11:0] E_AND   = 12'h180;
   localparam logic [11:0] E_OR    = 12'h1C0;
   localparam logic [11:0] E_ADDI  = 12'h500;
   localparam logic [11:0] E_ADDIU = 12'hD00;
   localparam logic [11:0] E_SUBI  = 12'h540;
   localparam logic [11:0] E_LI    = 12'h300;
   localparam logic [11:0] E_LD    = 12'h00A;
   localparam logic [11:0] E_LDW   = 12'h100;
   localparam logic [11:0] E_ST    = 12'h004;
   localparam logic [11:0] E_BEQ   = 12'h010;
   localparam logic [11:0] E_BGT   = 12'h020;
   localparam logic [11:0] E_JMP   = 12'h030;
   localparam logic [11:0] E_HALT  = 12'h003;

   typedef struct packed {
      logic        r;
      logic        v;
      logic        b;
      logic [3:0]  op;
      logic [11:0] ex;
   } step_t;

   logic       clk = 1'b0;
   logic       rst_r = 1'b1;
   logic [3:0] opcd_r = 4'h0;
   logic       valid_r = 1'b0;
   logic       br_r = 1'b0;

   logic       a_sel1, a_sel2, a_sel, a_w, a_mrd, a_mwr, a_stall, a_halted;
   logic [1:0] a_alu, a_jump;
   logic       b_sel1, b_sel2, b_sel, b_w, b_mrd, b_mwr, b_stall, b_halted;
   logic [1:0] b_alu, b_jump;
   logic [11:0] out_a, out_b;

   logic [11:0] sb_q[$];
   int checks = 0;
   int errors = 0;
   bit use_b = 1'b0;

   always #5 clk = ~clk;

   ctrl_fsm #(.LD_LAT(2), .FLUSH_CYC(1), .OPW(4)) dut_a (
      .clk(clk), .rst(rst_r), .opcd(opcd_r), .instr_valid(valid_r), .br_taken(br_r),
      .sel1(a_sel1), .sel2(a_sel2), .sel(a_sel), .w(a_w), .ALU(a_alu), .jump(a_jump),
      .mem_rd(a_mrd), .mem_wr(a_mwr), .stall(a_stall), .halted(a_halted));

   ctrl_fsm #(.LD_LAT(1), .FLUSH_CYC(0), .OPW(4)) dut_b (
      .clk(clk), .rst(rst_r), .opcd(opcd_r), .instr_valid(valid_r), .br_taken(br_r),
      .sel1(b_sel1), .sel2(b_sel2), .sel(b_sel), .w(b_w), .ALU(b_alu), .jump(b_jump),
      .mem_rd(b_mrd), .mem_wr(b_mwr), .stall(b_stall), .halted(b_halted));

   assign out_a = {a_sel1, a_sel2, a_sel, a_w, a_alu, a_jump, a_mrd, a_mwr, a_stall, a_halted};
   assign out_b = {b_sel1, b_sel2, b_sel, b_w, b_alu, b_jump, b_mrd, b_mwr, b_stall, b_halted};

   // Drive one cycle of stimulus, queue its expected result, sample after the edge.
   task automatic drive(input step_t s);
      rst_r   = s.r;
      opcd_r  = s.op;
      valid_r = s.v;
      br_r    = s.b;
      sb_q.push_back(s.ex);
      @(posedge clk);
      #1;
   endtask

   task automatic resync();
      rst_r = 1'b1; valid_r = 1'b0; opcd_r = 4'h0; br_r = 1'b0;
      @(posedge clk);
      #1;
      rst_r = 1'b0;
   endtask

   task automatic test_reset();
      logic [11:0] want;
      for (int i = 0; i < 2; i++) begin
         drive('{1'b1, 1'b1, 1'b1, 4'hF, E_NOP});
         want = sb_q.pop_front();
         checks++;
         if (out_a !== want) begin errors++; $display("FAIL reset_a[%0d] got %03h want %03h", i, out_a, want); end
         checks++;
         if (out_b !== want) begin errors++; $display("FAIL reset_b[%0d] got %03h want %03h", i, out_b, want); end
      end
   endtask

   task automatic test_alu();
      step_t st[4] = '{'{1'b0, 1'b1, 1'b0, 4'h1, E_ADD}, '{1'b0, 1'b1, 1'b0, 4'h2, E_SUB},
                       '{1'b0, 1'b1, 1'b0, 4'h3, E_AND}, '{1'b0, 1'b1, 1'b0, 4'h4, E_OR}};
      logic [11:0] want;
      use_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(st[i]);
         want = sb_q.pop_front();
         checks++;
         if (out_a !== want) begin errors++; $display("FAIL alu[%0d] got %03h want %03h", i, out_a, want); end
      end
   endtask

   task automatic test_imm();
      step_t st[8] = '{'{1'b0, 1'b1, 1'b0, 4'h5, E_ADDI}, '{1'b0, 1'b1, 1'b0, 4'h6, E_ADDIU},
                       '{1'b0, 1'b1, 1'b0, 4'h7, E_SUBI}, '{1'b0, 1'b1, 1'b0, 4'h8, E_LI},
                       '{1'b0, 1'b1, 1'b0, 4'h9, E_LI},   '{1'b0, 1'b1, 1'b0, 4'hB, E_ST},
                       '{1'b0, 1'b1, 1'b0, 4'h0, E_NOP},  '{1'b0, 1'b0, 1'b0, 4'h1, E_NOP}};
      logic [11:0] want;
      use_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(st[i]);
         want = sb_q.pop_front();
         checks++;
         if (out_a !== want) begin errors++; $display("FAIL imm[%0d] got %03h want %03h", i, out_a, want); end
      end
   endtask

   task automatic test_load();
      // LD_LAT=2: two mem_rd/stall cycles, one w cycle, then next opcode.
      step_t sa[4] = '{'{1'b0, 1'b1, 1'b0, 4'hA, E_LD}, '{1'b0, 1'b1, 1'b0, 4'hA, E_LD},
                       '{1'b0, 1'b1, 1'b0, 4'hA, E_LDW}, '{1'b0, 1'b1, 1'b0, 4'h2, E_SUB}};
      // LD_LAT=1: one mem_rd/stall cycle.
      step_t sb[3] = '{'{1'b0, 1'b1, 1'b0, 4'hA, E_LD}, '{1'b0, 1'b1, 1'b0, 4'hA, E_LDW},
                       '{1'b0, 1'b1, 1'b0, 4'h3, E_AND}};
      logic [11:0] want, got;
      resync();
      for (int i = 0; i < 4; i++) begin
         drive(sa[i]);
         want = sb_q.pop_front();
         got = out_a;
         checks++;
         if (got !== want) begin errors++; $display("FAIL ld2[%0d] got %03h want %03h", i, got, want); end
      end
      resync();
      for (int i = 0; i < 3; i++) begin
         drive(sb[i]);
         want = sb_q.pop_front();
         got = out_b;
         checks++;
         if (got !== want) begin errors++; $display("FAIL ld1[%0d] got %03h want %03h", i, got, want); end
      end
   endtask

   task automatic test_branch();
      step_t st[8] = '{'{1'b0, 1'b1, 1'b0, 4'hC, E_BEQ}, '{1'b0, 1'b1, 1'b1, 4'h1, E_NOP},
                       '{1'b0, 1'b1, 1'b0, 4'h2, E_SUB}, '{1'b0, 1'b1, 1'b1, 4'hD, E_BGT},
                       '{1'b0, 1'b1, 1'b0, 4'h1, E_ADD}, '{1'b0, 1'b1, 1'b0, 4'hE, E_JMP},
                       '{1'b0, 1'b1, 1'b0, 4'h2, E_NOP}, '{1'b0, 1'b1, 1'b0, 4'h4, E_OR}};
      // FLUSH_CYC=0: a taken branch or JUMP inserts no bubble.
      step_t s0[4] = '{'{1'b0, 1'b1, 1'b0, 4'hC, E_BEQ}, '{1'b0, 1'b1, 1'b1, 4'h1, E_ADD},
                       '{1'b0, 1'b1, 1'b0, 4'hE, E_JMP}, '{1'b0, 1'b1, 1'b0, 4'h2, E_SUB}};
      logic [11:0] want;
      resync();
      for (int i = 0; i < 8; i++) begin
         drive(st[i]);
         want = sb_q.pop_front();
         checks++;
         if (out_a !== want) begin errors++; $display("FAIL br[%0d] got %03h want %03h", i, out_a, want); end
      end
      resync();
      for (int i = 0; i < 4; i++) begin
         drive(s0[i]);
         want = sb_q.pop_front();
         checks++;
         if (out_b !== want) begin errors++; $display("FAIL br_nf[%0d] got %03h want %03h", i, out_b, want); end
      end
   endtask

   task automatic test_halt();
      step_t s;
      logic [11:0] want;
      resync();
      drive('{1'b0, 1'b1, 1'b0, 4'hF, E_HALT});
      want = sb_q.pop_front();
      checks++;
      if (out_a !== want) begin errors++; $display("FAIL halt_enter got %03h want %03h", out_a, want); end
      for (int i = 0; i < 20; i++) begin
         s.r = 1'b0; s.v = 1'b1; s.b = 1'($urandom_range(0, 1));
         s.op = 4'($urandom_range(0, 15)); s.ex = E_HALT;
         drive(s);
         want = sb_q.pop_front();
         checks++;
         if (out_a !== want) begin errors++; $display("FAIL halt_hold[%0d] got %03h want %03h", i, out_a, want); end
      end
   endtask

   task automatic test_reset_mid();
      step_t st[6] = '{'{1'b0, 1'b1, 1'b0, 4'hF, E_HALT}, '{1'b1, 1'b1, 1'b0, 4'h5, E_NOP},
                       '{1'b0, 1'b1, 1'b0, 4'h1, E_ADD},  '{1'b0, 1'b1, 1'b0, 4'hA, E_LD},
                       '{1'b1, 1'b1, 1'b0, 4'hA, E_NOP},  '{1'b0, 1'b1, 1'b0, 4'h1, E_ADD}};
      logic [11:0] want;
      for (int i = 0; i < 6; i++) begin
         drive(st[i]);
         want = sb_q.pop_front();
         checks++;
         if (out_a !== want) begin errors++; $display("FAIL rst_mid[%0d] got %03h want %03h", i, out_a, want); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_alu();
      test_imm();
      test_load();
      test_branch();
      test_halt();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
